// File: rtl/conv_tile_driver.sv
// Initiator-side controller for the 6x6 / 3x3 convolution engine: buffers one tile,
// resets the engine, streams the tile in, captures the 16 results and drains them to the host.
module conv_tile_driver #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [7:0]  load_data,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [19:0] res_data,
    output logic        res_last,
    output logic        busy,
    output logic        err,
    output logic        conv_reset,
    output logic        conv_start,
    output logic [7:0]  conv_idata,
    input  logic        conv_finish,
    input  logic [19:0] conv_odata
);

    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_LOAD,
        S_CRST,
        S_FEED,
        S_WAIT,
        S_CAPT,
        S_DRAIN
    } state_t;

    state_t state, state_next;

    logic [5:0]    lidx;
    logic [5:0]    fidx;
    logic [3:0]    cidx;
    logic [3:0]    didx;
    logic [WW-1:0] wcnt;
    logic          timeout_hit;

    logic [7:0]  tbuf [36];
    logic [19:0] rbuf [16];

    assign timeout_hit = (wcnt == WW'(TIMEOUT - 1));

    // NOTE: every output and next-state value gets a default before the case, so no path
    // through this block leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        load_ready = 1'b0;
        res_valid  = 1'b0;
        res_data   = '0;
        res_last   = 1'b0;
        busy       = 1'b1;
        conv_reset = 1'b0;
        conv_start = 1'b0;
        conv_idata = '0;
        unique case (state)
            S_LOAD: begin
                load_ready = 1'b1;
                busy       = 1'b0;
                if (load_valid && lidx == 6'd35) state_next = S_CRST;
            end
            S_CRST: begin
                conv_reset = 1'b1;
                state_next = S_FEED;
            end
            S_FEED: begin
                conv_start = 1'b1;
                conv_idata = tbuf[fidx];
                if (fidx == 6'd35) state_next = S_WAIT;
            end
            S_WAIT: begin
                // The engine keeps re-sampling its last position while it computes.
                conv_start = 1'b1;
                conv_idata = tbuf[35];
                if (conv_finish)      state_next = S_CAPT;
                else if (timeout_hit) state_next = S_LOAD;
            end
            S_CAPT: begin
                conv_start = 1'b1;
                conv_idata = tbuf[35];
                if (cidx == 4'd15) state_next = S_DRAIN;
            end
            S_DRAIN: begin
                res_valid = 1'b1;
                res_data  = rbuf[didx];
                res_last  = (didx == 4'd15);
                if (res_ready && didx == 4'd15) state_next = S_LOAD;
            end
            default: state_next = S_LOAD;
        endcase
    end

    // NOTE: registered state is updated with non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_LOAD;
            lidx  <= '0;
            fidx  <= '0;
            cidx  <= '0;
            didx  <= '0;
            wcnt  <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_next;
            unique case (state)
                S_LOAD: begin
                    if (load_valid) lidx <= (lidx == 6'd35) ? 6'd0 : lidx + 6'd1;
                end
                S_CRST: fidx <= '0;
                S_FEED: begin
                    fidx <= fidx + 6'd1;
                    wcnt <= '0;
                end
                S_WAIT: begin
                    wcnt <= wcnt + WW'(1);
                    cidx <= '0;
                    if (!conv_finish && timeout_hit) begin
                        err  <= 1'b1;
                        lidx <= '0;
                    end
                end
                S_CAPT: begin
                    cidx <= cidx + 4'd1;
                    didx <= '0;
                end
                S_DRAIN: begin
                    if (res_ready) begin
                        didx <= didx + 4'd1;
                        if (didx == 4'd15) begin
                            lidx <= '0;
                            fidx <= '0;
                            cidx <= '0;
                            wcnt <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: the buffers carry no reset; their contents are don't-care until overwritten.
    always_ff @(posedge clk) begin
        if (state == S_LOAD && load_valid) tbuf[lidx] <= load_data;
        if (state == S_CAPT)               rbuf[cidx] <= conv_odata;
    end

endmodule

// File: tb/tb_conv_tile_driver.sv
// Scoreboard bench for conv_tile_driver: a behavioural engine stub, a reference
// convolution model, randomized load/drain handshakes and directed corner cases.
module tb_conv_tile_driver;

    localparam int TIMEOUT = 64;
    localparam int KERN [9] = '{0, 1, 2, 2, 2, 0, 0, 1, 2};

    typedef logic signed [7:0] tile_t [36];
    typedef struct packed {
        logic [19:0] data;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_valid;
    logic        load_ready;
    logic [7:0]  load_data;
    logic        res_valid;
    logic        res_ready;
    logic [19:0] res_data;
    logic        res_last;
    logic        busy;
    logic        err;
    logic        conv_reset;
    logic        conv_start;
    logic [7:0]  conv_idata;
    logic        conv_finish = 1'b0;
    logic [19:0] conv_odata = '0;

    conv_tile_driver #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_last(res_last),
        .busy(busy), .err(err),
        .conv_reset(conv_reset), .conv_start(conv_start), .conv_idata(conv_idata),
        .conv_finish(conv_finish), .conv_odata(conv_odata)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int tiles_done = 0;
    int tiles_expected = 0;
    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic flag_fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Reference: 3x3 correlation of the 6x6 tile with the fixed kernel, plain integer math.
    function automatic logic [19:0] conv_at(input tile_t t, input int oi, input int oj);
        int acc;
        acc = 0;
        for (int ki = 0; ki < 3; ki++)
            for (int kj = 0; kj < 3; kj++)
                acc += int'(t[(oi + ki) * 6 + oj + kj]) * KERN[ki * 3 + kj];
        return acc[19:0];
    endfunction

    // ---------------- engine stub ----------------
    logic        eng_dead = 1'b0;
    int          eng_lat = 16;
    tile_t       eng_smp;
    logic [19:0] eng_res [16];
    int          eng_n = 0;
    int          eng_wait = 0;
    int          eng_oidx = 0;

    always_comb begin
        for (int k = 0; k < 16; k++) eng_res[k] = conv_at(eng_smp, k / 4, k % 4);
    end

    always @(posedge clk) begin
        if (conv_reset) begin
            eng_n       <= 0;
            eng_wait    <= 0;
            eng_oidx    <= 0;
            conv_finish <= 1'b0;
        end else begin
            if (conv_finish && eng_oidx < 16) begin
                conv_odata <= eng_res[eng_oidx];
                eng_oidx   <= eng_oidx + 1;
            end
            if (conv_start && eng_n < 36) begin
                eng_smp[eng_n] <= conv_idata;
                eng_n          <= eng_n + 1;
            end else if (eng_n == 36 && !conv_finish && !eng_dead) begin
                if (eng_wait + 1 >= eng_lat) conv_finish <= 1'b1;
                eng_wait <= eng_wait + 1;
            end
        end
    end

    // ---------------- result monitor ----------------
    logic        hold_v = 1'b0;
    logic [19:0] hold_d;
    logic        hold_l;

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                check("hold_valid", 32'(res_valid), 32'd1);
                check("hold_data", 32'(res_data), 32'(hold_d));
                check("hold_last", 32'(res_last), 32'(hold_l));
            end
            if (res_valid && res_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_result: got 0x%0h, required none", res_data);
                end else begin
                    e = sb.pop_front();
                    check("res_data", 32'(res_data), 32'(e.data));
                    check("res_last", 32'(res_last), 32'(e.last));
                    if (e.last) tiles_done++;
                end
            end
            hold_v = res_valid && !res_ready;
            hold_d = res_data;
            hold_l = res_last;
        end
    end

    // conv_reset must be a lone one-cycle pulse right before conv_start rises.
    logic prev_start = 1'b0;
    logic prev_crst = 1'b0;
    int   crst_run = 0;
    int   crst_last = 0;
    int   start_run = 0;
    int   start_last = 0;

    always @(negedge clk) begin
        if (!conv_reset && prev_crst) crst_last = crst_run;
        if (!conv_start && prev_start) start_last = start_run;
        if (conv_start && !prev_start) begin
            check("crst_before_start", 32'(prev_crst), 32'd1);
            check("crst_pulse_len", 32'(crst_last), 32'd1);
        end
        crst_run   = conv_reset ? crst_run + 1 : 0;
        start_run  = conv_start ? start_run + 1 : 0;
        prev_crst  = conv_reset;
        prev_start = conv_start;
    end

    // ---------------- host side ----------------
    logic rdy_rand = 1'b0;

    initial begin
        res_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            res_ready = rdy_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    task automatic push_tile(input tile_t t);
        exp_t e;
        for (int k = 0; k < 16; k++) begin
            e.data = conv_at(t, k / 4, k % 4);
            e.last = (k == 15);
            sb.push_back(e);
        end
        tiles_expected++;
    endtask

    task automatic push_rows(input logic [19:0] r0, input logic [19:0] r1,
                             input logic [19:0] r2, input logic [19:0] r3);
        exp_t e;
        for (int k = 0; k < 16; k++) begin
            case (k / 4)
                0:       e.data = r0;
                1:       e.data = r1;
                2:       e.data = r2;
                default: e.data = r3;
            endcase
            e.last = (k == 15);
            sb.push_back(e);
        end
        tiles_expected++;
    endtask

    task automatic send_tile(input tile_t t, input int gap_max);
        logic hs;
        for (int k = 0; k < 36; k++) begin
            if (gap_max > 0) begin
                load_valid = 1'b0;
                repeat ($urandom_range(0, gap_max)) begin
                    @(posedge clk);
                    #1;
                end
            end
            load_valid = 1'b1;
            load_data  = t[k];
            hs = 1'b0;
            for (int c = 0; c < 600 && !hs; c++) begin
                @(negedge clk);
                hs = load_ready;
                @(posedge clk);
                #1;
            end
            if (!hs) begin
                flag_fail("load_handshake");
                load_valid = 1'b0;
                return;
            end
        end
        load_valid = 1'b0;
    endtask

    task automatic wait_tiles(input string name);
        for (int c = 0; c < 4000 && tiles_done < tiles_expected; c++) begin
            @(posedge clk);
            #1;
        end
        if (tiles_done < tiles_expected) flag_fail(name);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_load_ready"}, 32'(load_ready), 32'd1);
        check({tag, "_res_valid"},  32'(res_valid),  32'd0);
        check({tag, "_res_last"},   32'(res_last),   32'd0);
        check({tag, "_res_data"},   32'(res_data),   32'd0);
        check({tag, "_busy"},       32'(busy),       32'd0);
        check({tag, "_err"},        32'(err),        32'd0);
        check({tag, "_conv_reset"}, 32'(conv_reset), 32'd0);
        check({tag, "_conv_start"}, 32'(conv_start), 32'd0);
        check({tag, "_conv_idata"}, 32'(conv_idata), 32'd0);
    endtask

    function automatic tile_t rand_tile();
        tile_t t;
        for (int k = 0; k < 36; k++) t[k] = 8'($urandom);
        return t;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tile_t t;
        int    seen;

        reset      = 1'b1;
        load_valid = 1'b0;
        load_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        reset = 1'b0;

        // All-ones tile: every window sums the kernel, 10.
        for (int k = 0; k < 36; k++) t[k] = 8'sd1;
        push_rows(20'd10, 20'd10, 20'd10, 20'd10);
        send_tile(t, 0);
        wait_tiles("ones_done");
        check("ones_err", 32'(err), 32'd0);

        // Rows numbered from 1: kernel row sums 3,4,3 give 10*r+20.
        for (int k = 0; k < 36; k++) t[k] = 8'(k / 6 + 1);
        push_rows(20'd20, 20'd30, 20'd40, 20'd50);
        send_tile(t, 0);
        wait_tiles("rows_done");

        // Most negative sample everywhere: -1280.
        for (int k = 0; k < 36; k++) t[k] = -8'sd128;
        push_rows(20'hFFB00, 20'hFFB00, 20'hFFB00, 20'hFFB00);
        send_tile(t, 0);
        wait_tiles("neg_done");

        // Two back-to-back random tiles with random gaps on both sides.
        rdy_rand = 1'b1;
        eng_lat  = $urandom_range(1, 20);
        begin
            tile_t t2;
            t  = rand_tile();
            t2 = rand_tile();
            push_tile(t);
            push_tile(t2);
            send_tile(t, 3);
            send_tile(t2, 3);
        end
        wait_tiles("rand_done");
        rdy_rand = 1'b0;

        // Dead engine: FEED (36) + WAIT (TIMEOUT) cycles of conv_start, then abort.
        eng_dead = 1'b1;
        check("pre_timeout_err", 32'(err), 32'd0);
        send_tile(rand_tile(), 0);
        seen = 0;
        for (int c = 0; c < 400 && seen == 0; c++) begin
            @(negedge clk);
            if (!busy) seen = 1;
        end
        if (seen == 0) flag_fail("timeout_return");
        @(posedge clk);
        #1;
        check("timeout_err", 32'(err), 32'd1);
        check("timeout_start", 32'(conv_start), 32'd0);
        check("timeout_load_ready", 32'(load_ready), 32'd1);
        check("timeout_start_len", 32'(start_last), 32'(36 + TIMEOUT));
        eng_dead = 1'b0;

        // Recovery tile with a live engine; err remains sticky.
        eng_lat = $urandom_range(1, 20);
        t = rand_tile();
        push_tile(t);
        send_tile(t, 1);
        wait_tiles("recover_done");
        check("sticky_err", 32'(err), 32'd1);

        // Reset in the middle of CAPT.
        t = rand_tile();
        push_tile(t);
        send_tile(t, 0);
        seen = 0;
        for (int c = 0; c < 200 && seen == 0; c++) begin
            @(negedge clk);
            if (conv_finish) seen = 1;
        end
        if (seen == 0) flag_fail("capt_reach");
        @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        sb.delete();
        tiles_expected--;
        @(posedge clk);
        #1;
        check_reset_outputs("midrst");
        reset = 1'b0;

        // Fresh tile after the abort.
        t = rand_tile();
        push_tile(t);
        send_tile(t, 2);
        wait_tiles("fresh_done");
        check("leftover_expect", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
